// File: rtl/gpu_video_timing_gen.sv
// Raster timing generator: walks x/y counters through active, porch and sync regions
// and registers sync, active, coordinate and line/frame strobes decoded from next-state counters.
module gpu_video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $fatal(1, "gpu_video_timing_gen: every timing parameter must be >= 1");
  end
  if ((HSYNC_POL != 0 && HSYNC_POL != 1) || (VSYNC_POL != 0 && VSYNC_POL != 1)) begin : g_bad_pol
    $fatal(1, "gpu_video_timing_gen: sync polarities must be 0 or 1");
  end

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON      = 1'(HSYNC_POL);
  localparam logic          VS_ON      = 1'(VSYNC_POL);

  logic [HW-1:0] r_x;
  logic [VW-1:0] r_y;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_active;
  logic          r_line_start;
  logic          r_frame_start;

  logic [HW-1:0] w_x_nxt;
  logic [VW-1:0] w_y_nxt;
  logic          w_hsync_nxt;
  logic          w_vsync_nxt;
  logic          w_active_nxt;
  logic          w_line_start_nxt;
  logic          w_frame_start_nxt;

  // Next raster position: x wraps at end of line and carries into y.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (pix_en) begin
      if (r_x == H_LAST) begin
        w_x_nxt = {HW{1'b0}};
        if (r_y == V_LAST) begin
          w_y_nxt = {VW{1'b0}};
        end else begin
          w_y_nxt = r_y + VW'(1);
        end
      end else begin
        w_x_nxt = r_x + HW'(1);
        w_y_nxt = r_y;
      end
    end else begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
    end
  end

  // Region decode on the next position so the registered outputs line up with x/y.
  always_comb begin
    w_active_nxt      = (w_x_nxt < H_ACT_END) && (w_y_nxt < V_ACT_END);
    w_hsync_nxt       = ((w_x_nxt >= H_SYNC_BEG) && (w_x_nxt < H_SYNC_END)) ? HS_ON : ~HS_ON;
    w_vsync_nxt       = ((w_y_nxt >= V_SYNC_BEG) && (w_y_nxt < V_SYNC_END)) ? VS_ON : ~VS_ON;
    w_line_start_nxt  = pix_en && (w_x_nxt == {HW{1'b0}});
    w_frame_start_nxt = w_line_start_nxt && (w_y_nxt == {VW{1'b0}});
  end

  // State and output registers; reset parks on the last pixel of the frame.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_active      <= 1'b0;
      r_hsync       <= ~HS_ON;
      r_vsync       <= ~VS_ON;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_active      <= w_active_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign active      = r_active;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
